load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Parametrised successor to the processor's load-size selector.
- Sits between the memory data register and the register-file write port.
- Extracts a byte, halfword or full word from any byte offset, with optional sign extension.
- Sequences the memory beats with a small FSM and returns a registered result plus a done pulse to the control unit.

Parameters:
- DATA_W, 32: memory bus and result width in bits; power of two, at least 16.
- BYTES, DATA_W/8: derived; bytes per bus word.
- OFF_W, $clog2(DATA_W/8): derived; width of the byte offset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a load; sampled only in IDLE.
- load_size  input  2  access size: 00 = word (BYTES bytes), 01 = half (2 bytes), 10 = byte, 11 = reserved.
- sign_ext  input  1  1 = sign-extend the field, 0 = zero-extend.
- addr_off  input  OFF_W  byte offset of the access within the bus word.
- mem_req  output  1  high while a memory beat is awaited.
- mem_beat  output  1  0 = word at the base address, 1 = following word (base + BYTES).
- mem_valid  input  1  memory data valid for the current beat.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- write_data  output  DATA_W  extracted and extended result; held between completions.
- align_err  output  1  error flag; pulses together with done.

Behaviour:
- Reset (async, reset_n=0): state = IDLE; mem_req, mem_beat, busy, done, align_err and write_data all 0. Beat capture registers are cleared.
- Reset mid-operation aborts the access immediately. mem_req drops combinationally with the state. No done pulse is produced for the aborted access.
- On start in IDLE, latch load_size, sign_ext and addr_off.
  - nbytes = BYTES / 2 / 1 for size 00 / 01 / 10.
  - cross = (addr_off + nbytes > BYTES).
- FSM states and transitions:
  - IDLE:
    - start with size 11 -> FIN with err = 1.
    - start with cross=1 and MISALIGN_SPLIT_EN undefined -> FIN with err = 1.
    - any other start -> REQ1.
  - REQ1: mem_req=1, mem_beat=0. On mem_valid, lo <= mem_rdata, then go to REQ2 if cross, else FIN.
  - REQ2: mem_req=1, mem_beat=1. On mem_valid, hi <= mem_rdata, then go to FIN.
  - FIN: done=1 for exactly one cycle, write_data and align_err updated in the same cycle, then return to IDLE.
- Extraction:
  - field = ({hi, lo} >> (8*addr_off)) truncated to nbytes.
  - The upper bits are filled with the field's MSB when sign_ext=1, otherwise with 0.
  - hi = 0 for non-crossing accesses.
  - A word access with addr_off = 0 passes the data through unchanged.
- Error completion: write_data = 0, align_err = 1, mem_req is never asserted.
- Latency:
  - done is high in the cycle after the final accepted mem_valid.
  - An error completion raises done in the cycle after start.
- Boundaries:
  - start while busy is ignored; the latched request is unchanged.
  - mem_valid outside REQ1/REQ2 is ignored.
  - mem_valid held high for several cycles advances exactly one beat per state.
  - start in the same cycle as done (FIN) is ignored; start is accepted from the next IDLE cycle.
  - write_data holds its value after done until the next completion.
  - A word access with addr_off ≠ 0 counts as crossing.

Optional Feature:
- MISALIGN_SPLIT_EN defined: crossing accesses run REQ1 then REQ2 and merge the two beats as described above.
- MISALIGN_SPLIT_EN undefined: the REQ2 state is not built. Crossing accesses complete as errors (done + align_err, write_data = 0, no memory beat).

Test Plan:
- Word load, DATA_W=32: load_size=00, addr_off=0, mem_valid 3 cycles after start with mem_rdata=0xDEADBEEF -> write_data=0xDEADBEEF; done one cycle after mem_valid; align_err=0; mem_beat=0 throughout.
- Byte load, mem_rdata=0x80FF1234, load_size=10, addr_off=3:
  - sign_ext=1 -> 0xFFFFFF80.
  - sign_ext=0 -> 0x00000080.
  - addr_off=1, sign_ext=1 -> 0x00000012.
- Half load, mem_rdata=0xABCD5678, load_size=01:
  - addr_off=2, sign_ext=0 -> 0x0000ABCD.
  - addr_off=2, sign_ext=1 -> 0xFFFFABCD.
  - addr_off=0, sign_ext=1 -> 0x00005678.
- Crossing half, load_size=01, addr_off=3, beat0=0x11000000, beat1=0x00000022:
  - With MISALIGN_SPLIT_EN -> two mem_req phases (mem_beat 0 then 1), write_data=0x00002211.
  - Without it -> mem_req stays 0, done+align_err one cycle after start, write_data=0.
- Reserved size and busy handling: load_size=11 -> align_err=1, write_data=0, no mem_req. A second start pulsed during REQ1 -> ignored; only one done is produced.
- Reset mid-operation: reset_n=0 during REQ1 (or REQ2) -> mem_req, busy, done and write_data all 0 immediately. After release, the next load completes normally.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: extracts a byte, halfword or word at any byte offset of the memory bus, with optional sign extension.
// Define MISALIGN_SPLIT_EN to service offset-crossing loads with a second memory beat; otherwise they complete as errors.
module load_align_unit #(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        load_size,
    input  logic              sign_ext,
    input  logic [OFF_W-1:0]  addr_off,
    output logic              mem_req,
    output logic              mem_beat,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] write_data,
    output logic              align_err
);

`ifdef MISALIGN_SPLIT_EN
    localparam int PAIR_W = 2 * DATA_W;
`else
    localparam int PAIR_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        REQ1,
`ifdef MISALIGN_SPLIT_EN
        REQ2,
`endif
        FIN
    } state_e;

    state_e             state_q;
    logic [1:0]         loadSize_q;
    logic               signExt_q;
    logic [OFF_W-1:0]   addrOff_q;
    logic               memReq_q;
    logic               memBeat_q;
    logic               busy_q;
    logic               done_q;
    logic               alignErr_q;
    logic [DATA_W-1:0]  writeData_q;
`ifdef MISALIGN_SPLIT_EN
    logic [DATA_W-1:0]  lo_q;
`endif

    logic               startErr;
    logic [PAIR_W-1:0]  pair;
    logic [OFF_W+2:0]   shamt;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  mask;
    logic               signBit;
    logic [DATA_W-1:0]  extract_d;

    // A field crosses into the next bus word when it does not fit after the offset.
    function automatic logic isCross(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic c;
        c = 1'b0;
        case (size)
            2'b00:   c = (off != '0);
            2'b01:   c = (off == OFF_W'(BYTES - 1));
            default: c = 1'b0;
        endcase
        return c;
    endfunction

`ifdef MISALIGN_SPLIT_EN
    assign startErr = (load_size == 2'b11);
`else
    assign startErr = (load_size == 2'b11) || isCross(load_size, addr_off);
`endif

    // The final beat's data is used straight from the bus so the result lands together with done.
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        pair = (state_q == REQ2) ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
`else
        pair = mem_rdata;
`endif
        shamt   = {addrOff_q, 3'b000};
        shifted = DATA_W'(pair >> shamt);
        mask    = {DATA_W{1'b1}};
        signBit = shifted[DATA_W-1];
        case (loadSize_q)
            2'b01: begin
                mask    = DATA_W'(16'hFFFF);
                signBit = shifted[15];
            end
            2'b10: begin
                mask    = DATA_W'(8'hFF);
                signBit = shifted[7];
            end
            default: ;
        endcase
        extract_d = (shifted & mask) | ((signExt_q && signBit) ? ~mask : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            loadSize_q  <= '0;
            signExt_q   <= 1'b0;
            addrOff_q   <= '0;
            memReq_q    <= 1'b0;
            memBeat_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alignErr_q  <= 1'b0;
            writeData_q <= '0;
`ifdef MISALIGN_SPLIT_EN
            lo_q        <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        loadSize_q <= load_size;
                        signExt_q  <= sign_ext;
                        addrOff_q  <= addr_off;
                        busy_q     <= 1'b1;
                        if (startErr) begin
                            state_q     <= FIN;
                            done_q      <= 1'b1;
                            alignErr_q  <= 1'b1;
                            writeData_q <= '0;
                        end else begin
                            state_q   <= REQ1;
                            memReq_q  <= 1'b1;
                            memBeat_q <= 1'b0;
                        end
                    end
                end
                REQ1: begin
                    if (mem_valid) begin
`ifdef MISALIGN_SPLIT_EN
                        if (isCross(loadSize_q, addrOff_q)) begin
                            lo_q      <= mem_rdata;
                            state_q   <= REQ2;
                            memBeat_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= FIN;
                            memReq_q    <= 1'b0;
                            done_q      <= 1'b1;
                            alignErr_q  <= 1'b0;
                            writeData_q <= extract_d;
                        end
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                REQ2: begin
                    if (mem_valid) begin
                        state_q     <= FIN;
                        memReq_q    <= 1'b0;
                        memBeat_q   <= 1'b0;
                        done_q      <= 1'b1;
                        alignErr_q  <= 1'b0;
                        writeData_q <= extract_d;
                    end
                end
`endif
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = memReq_q;
    assign mem_beat   = memBeat_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign align_err  = alignErr_q;
    assign write_data = writeData_q;

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed loads checked each cycle against a byte-level reference model plus literal results.
module tb_load_align_unit;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  load_size;
    logic        sign_ext;
    logic [1:0]  addr_off;
    logic        mem_req;
    logic        mem_beat;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] write_data;
    logic        align_err;

    int checks;
    int failures;

    load_align_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .load_size  (load_size),
        .sign_ext   (sign_ext),
        .addr_off   (addr_off),
        .mem_req    (mem_req),
        .mem_beat   (mem_beat),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .write_data (write_data),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction seen as a list of received bus bytes.
    int          phase;
    int          beatsNeed;
    int          beatsGot;
    int          mOff;
    int          mNb;
    logic        mSign;
    logic [7:0]  mbuf [0:7];
    logic        mBusy, mReq, mBeat, mDone, mErr;
    logic [31:0] mWd;

    function automatic int nbytesOf(input logic [1:0] size);
        case (size)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] assemble();
        logic [31:0] v;
        logic        neg;
        v = 32'h0;
        for (int i = 0; i < mNb; i++) v[8*i +: 8] = mbuf[mOff + i];
        neg = mbuf[mOff + mNb - 1][7];
        if (mSign && neg)
            for (int i = mNb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase = 0; beatsNeed = 0; beatsGot = 0; mOff = 0; mNb = 0; mSign = 1'b0;
            mBusy = 1'b0; mReq = 1'b0; mBeat = 1'b0; mDone = 1'b0; mErr = 1'b0; mWd = 32'h0;
        end else begin
            mDone = 1'b0;
            case (phase)
                0: if (start) begin
                    mOff  = int'(addr_off);
                    mNb   = nbytesOf(load_size);
                    mSign = sign_ext;
                    mBusy = 1'b1;
                    if (load_size == 2'b11 || ((mOff + mNb > 4) && !SPLIT)) begin
                        phase = 2; mDone = 1'b1; mErr = 1'b1; mWd = 32'h0;
                    end else begin
                        phase = 1; beatsGot = 0; mReq = 1'b1; mBeat = 1'b0;
                        beatsNeed = (mOff + mNb > 4) ? 2 : 1;
                        for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
                    end
                end
                1: if (mem_valid) begin
                    for (int i = 0; i < 4; i++) mbuf[beatsGot*4 + i] = mem_rdata[8*i +: 8];
                    beatsGot++;
                    if (beatsGot == beatsNeed) begin
                        phase = 2; mReq = 1'b0; mBeat = 1'b0; mDone = 1'b1; mErr = 1'b0;
                        mWd = assemble();
                    end else begin
                        mBeat = 1'b1;
                    end
                end
                default: begin
                    phase = 0; mBusy = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", {31'h0, busy}, {31'h0, mBusy});
        checkOutput("mem_req", {31'h0, mem_req}, {31'h0, mReq});
        checkOutput("mem_beat", {31'h0, mem_beat}, {31'h0, mBeat});
        checkOutput("done", {31'h0, done}, {31'h0, mDone});
        checkOutput("align_err", {31'h0, align_err}, {31'h0, mErr});
        checkOutput("write_data", write_data, mWd);
    end

    // Issues one load, answers memory beats after lat request cycles, and returns the completion values.
    task automatic applyStimulus(input logic [1:0] size, input logic sx, input logic [1:0] off,
                                 input logic [31:0] b0, input logic [31:0] b1, input int lat,
                                 input bit poke, output logic [31:0] wd, output logic err);
        int  cycles;
        int  waitCnt;
        bit  gotDone;
        @(posedge clk); #2;
        start = 1'b1; load_size = size; sign_ext = sx; addr_off = off;
        @(posedge clk); #2;
        start = 1'b0;
        cycles = 0; waitCnt = 0; gotDone = 1'b0; wd = 32'h0; err = 1'b0;
        while (!gotDone && cycles < 50) begin
            start = 1'b0;
            if (done) begin
                gotDone = 1'b1; wd = write_data; err = align_err;
            end else begin
                mem_valid = 1'b0;
                if (mem_req) begin
                    if (waitCnt >= lat) begin
                        mem_valid = 1'b1;
                        mem_rdata = mem_beat ? b1 : b0;
                        waitCnt = 0;
                    end else begin
                        if (poke && waitCnt == 0) begin
                            start = 1'b1; load_size = 2'b00; sign_ext = 1'b1; addr_off = 2'd0;
                        end
                        waitCnt++;
                    end
                end
                @(posedge clk); #2;
                cycles++;
            end
        end
        mem_valid = 1'b0;
        start = 1'b0;
        checkOutput("done_seen", {31'h0, gotDone}, 32'h1);
    endtask

    logic [31:0] wd;
    logic        err;

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0; start = 1'b0; load_size = 2'b00; sign_ext = 1'b0; addr_off = 2'd0;
        mem_valid = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        checkOutput("reset_write_data", write_data, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        applyStimulus(2'b00, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 2, 1'b0, wd, err);
        checkOutput("word_wd", wd, 32'hDEADBEEF);
        checkOutput("word_err", {31'h0, err}, 32'h0);

        applyStimulus(2'b10, 1'b1, 2'd3, 32'h80FF1234, 32'h0, 1, 1'b0, wd, err);
        checkOutput("byte3_sx", wd, 32'hFFFFFF80);
        applyStimulus(2'b10, 1'b0, 2'd3, 32'h80FF1234, 32'h0, 0, 1'b0, wd, err);
        checkOutput("byte3_zx", wd, 32'h00000080);
        applyStimulus(2'b10, 1'b1, 2'd1, 32'h80FF1234, 32'h0, 0, 1'b0, wd, err);
        checkOutput("byte1_sx", wd, 32'h00000012);

        applyStimulus(2'b01, 1'b0, 2'd2, 32'hABCD5678, 32'h0, 1, 1'b0, wd, err);
        checkOutput("half2_zx", wd, 32'h0000ABCD);
        applyStimulus(2'b01, 1'b1, 2'd2, 32'hABCD5678, 32'h0, 0, 1'b0, wd, err);
        checkOutput("half2_sx", wd, 32'hFFFFABCD);
        applyStimulus(2'b01, 1'b1, 2'd0, 32'hABCD5678, 32'h0, 0, 1'b0, wd, err);
        checkOutput("half0_sx", wd, 32'h00005678);

        applyStimulus(2'b01, 1'b0, 2'd3, 32'h11000000, 32'h00000022, 1, 1'b0, wd, err);
        checkOutput("cross_half_wd", wd, SPLIT ? 32'h00002211 : 32'h0);
        checkOutput("cross_half_err", {31'h0, err}, SPLIT ? 32'h0 : 32'h1);

        applyStimulus(2'b00, 1'b0, 2'd1, 32'h44332211, 32'h88776655, 0, 1'b0, wd, err);
        checkOutput("cross_word_wd", wd, SPLIT ? 32'h55443322 : 32'h0);

        applyStimulus(2'b11, 1'b0, 2'd0, 32'h12345678, 32'h0, 0, 1'b0, wd, err);
        checkOutput("reserved_wd", wd, 32'h0);
        checkOutput("reserved_err", {31'h0, err}, 32'h1);

        applyStimulus(2'b10, 1'b0, 2'd0, 32'hFFFFFFF0, 32'h0, 2, 1'b1, wd, err);
        checkOutput("busy_start_wd", wd, 32'h000000F0);

        // start presented during the done cycle must not launch a load
        start = 1'b1; load_size = 2'b10; sign_ext = 1'b0; addr_off = 2'd0;
        @(posedge clk); #2;
        start = 1'b0;
        checkOutput("fin_start_busy", {31'h0, busy}, 32'h0);
        checkOutput("hold_wd", write_data, 32'h000000F0);

        mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #2 mem_valid = 1'b0;
        checkOutput("idle_valid_busy", {31'h0, busy}, 32'h0);

        start = 1'b1; load_size = 2'b00; sign_ext = 1'b0; addr_off = 2'd0;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_write_data", write_data, 32'h0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        applyStimulus(2'b01, 1'b1, 2'd0, 32'h0000BEEF, 32'h0, 1, 1'b0, wd, err);
        checkOutput("post_rst_wd", wd, 32'hFFFFBEEF);

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
